// File: rtl/pipe_pkg.sv
// Shared Y86-64 PIPE definitions: icodes, status codes,
// register-none code and the F->D bundle with its bubble value.
package pipe_pkg;
  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSHQ = 4'hA;
  localparam logic [3:0] I_POPQ  = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 4'd4;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } if_id_t;

  localparam if_id_t D_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    valc:  64'h0,
    valp:  64'h0
  };
endpackage

// File: rtl/pipe_predecode.sv
// Combinational fetch decode: splits the 10-byte window at pc into
// icode/ifun/ra/rb/valc, computes valp, stat and the predicted next PC.
module pipe_predecode
  import pipe_pkg::*;
(
  input  logic [79:0] imem_data,
  input  logic        imem_error,
  input  logic [63:0] f_pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valc,
  output logic [63:0] valp,
  output logic [2:0]  stat,
  output logic [63:0] pred_pc
);
  logic ifun_ok;
  logic valid;
  logic need_regids;
  logic need_valc;

  assign icode = imem_error ? I_NOP : imem_data[7:4];
  assign ifun  = imem_error ? 4'h0 : imem_data[3:0];

  always_comb begin
    ifun_ok = 1'b0;
    case (icode)
      I_OPQ:          ifun_ok = (ifun <= 4'd3);
      I_JXX, I_CMOV:  ifun_ok = (ifun <= 4'd6);
      default:        ifun_ok = (ifun == 4'd0);
    endcase
  end

  assign valid = (icode <= I_POPQ) && ifun_ok;

  assign need_regids = icode inside {I_CMOV, I_IRMOV,
    I_RMMOV, I_MRMOV, I_OPQ, I_PUSHQ, I_POPQ};
  assign need_valc = icode inside {I_IRMOV, I_RMMOV,
    I_MRMOV, I_JXX, I_CALL};

  assign ra = need_regids ? imem_data[15:12] : RNONE;
  assign rb = need_regids ? imem_data[11:8] : RNONE;

  always_comb begin
    valc = 64'h0;
    if (need_valc)
      valc = need_regids ? imem_data[79:16]
                         : imem_data[71:8];
  end

  assign valp = f_pc + 64'd1
              + {63'h0, need_regids}
              + (need_valc ? 64'd8 : 64'd0);

  always_comb begin
    stat = STAT_AOK;
    if (imem_error)          stat = STAT_ADR;
    else if (!valid)         stat = STAT_INS;
    else if (icode == I_HALT) stat = STAT_HLT;
  end

  // jXX is always predicted taken
  assign pred_pc = (icode == I_JXX || icode == I_CALL)
                 ? valc : valp;
endmodule

// File: rtl/pipe_fetch.sv
// Y86-64 PIPE fetch stage + F->D register (macro FETCH_PERF_CNT_EN adds
// saturating perf counters). Ports: clk, reset (async, low), stall/bubble
// controls, M/W redirect inputs, imem_*, D_* outputs, perf_* counters.
module pipe_fetch
  import pipe_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             F_stall,
  input  logic             D_stall,
  input  logic             D_bubble,
  input  logic [3:0]       M_icode,
  input  logic             M_Cnd,
  input  logic [63:0]      M_valA,
  input  logic [3:0]       W_icode,
  input  logic [63:0]      W_valM,
  output logic [63:0]      imem_addr,
  input  logic [79:0]      imem_data,
  input  logic             imem_error,
  output logic [2:0]       D_stat,
  output logic [3:0]       D_icode,
  output logic [3:0]       D_ifun,
  output logic [3:0]       D_rA,
  output logic [3:0]       D_rB,
  output logic [63:0]      D_valC,
  output logic [63:0]      D_valP,
  output logic [CNT_W-1:0] perf_fetched,
  output logic [CNT_W-1:0] perf_bubbles,
  output logic [CNT_W-1:0] perf_stalls
);
  logic [63:0] pred_q;
  logic [63:0] f_pc;
  logic [63:0] pred_next;
  if_id_t      f_d;
  if_id_t      d_q;

  // mispredicted branch has priority over ret
  always_comb begin
    f_pc = pred_q;
    if (M_icode == I_JXX && !M_Cnd) f_pc = M_valA;
    else if (W_icode == I_RET)      f_pc = W_valM;
  end

  assign imem_addr = f_pc;

  pipe_predecode u_pre (
    .imem_data  (imem_data),
    .imem_error (imem_error),
    .f_pc       (f_pc),
    .icode      (f_d.icode),
    .ifun       (f_d.ifun),
    .ra         (f_d.ra),
    .rb         (f_d.rb),
    .valc       (f_d.valc),
    .valp       (f_d.valp),
    .stat       (f_d.stat),
    .pred_pc    (pred_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       pred_q <= RESET_PC;
    else if (!F_stall) pred_q <= pred_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        d_q <= D_BUBBLE;
    else if (D_stall)  d_q <= d_q;
    else if (D_bubble) d_q <= D_BUBBLE;
    else               d_q <= f_d;
  end

`ifndef SYNTHESIS
  always @(posedge clk)
    if (reset && D_stall && D_bubble)
      $error("pipe_fetch: D_stall and D_bubble both high");
`endif

  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_rA    = d_q.ra;
  assign D_rB    = d_q.rb;
  assign D_valC  = d_q.valc;
  assign D_valP  = d_q.valp;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fet_q;
  logic [CNT_W-1:0] bub_q;
  logic [CNT_W-1:0] stl_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fet_q <= '0;
      bub_q <= '0;
      stl_q <= '0;
    end else begin
      if (D_stall)
        stl_q <= stl_q + {{(CNT_W-1){1'b0}}, ~&stl_q};
      else if (D_bubble)
        bub_q <= bub_q + {{(CNT_W-1){1'b0}}, ~&bub_q};
      else
        fet_q <= fet_q + {{(CNT_W-1){1'b0}}, ~&fet_q};
    end
  end

  assign perf_fetched = fet_q;
  assign perf_bubbles = bub_q;
  assign perf_stalls  = stl_q;
`else
  assign perf_fetched = '0;
  assign perf_bubbles = '0;
  assign perf_stalls  = '0;
`endif
endmodule

// File: tb/tb_pipe_fetch.sv
// Directed table-driven bench for pipe_fetch plus hand sequences for
// redirects, stall/bubble, PC wrap, counters and async reset.
module tb_pipe_fetch;
  localparam logic [63:0] RPC = 64'h100;
  localparam int CW = 4;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic F_stall, D_stall, D_bubble;
  logic [3:0] M_icode, W_icode;
  logic M_Cnd;
  logic [63:0] M_valA, W_valM;
  logic [63:0] imem_addr;
  logic [79:0] imem_data;
  logic imem_error;
  logic [2:0] D_stat;
  logic [3:0] D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [CW-1:0] perf_fetched, perf_bubbles, perf_stalls;

  pipe_fetch #(.RESET_PC(RPC), .CNT_W(CW)) dut (
    .clk(clk), .reset(rst_n),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .imem_error(imem_error),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
    .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles),
    .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] data;
    logic        err;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] len;
    logic        jmp;
    logic [2:0]  stat;
  } vec_t;

  vec_t v[20];
  int total = 0;
  int bad = 0;
  int ef = 0, eb = 0, es = 0;
  logic [63:0] exp_pc;
  logic [63:0] jpc;

  function automatic int inc(input int x);
    if (!PERF) return 0;
    return (x == 15) ? 15 : x + 1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (D_stall)       es = inc(es);
      else if (D_bubble) eb = inc(eb);
      else               ef = inc(ef);
    end
    #1;
  endtask

  task automatic chk_bubble(input string nm);
    chk({nm, ".stat"}, 64'(D_stat), 64'd1);
    chk({nm, ".icode"}, 64'(D_icode), 64'h1);
    chk({nm, ".ifun"}, 64'(D_ifun), 64'h0);
    chk({nm, ".rA"}, 64'(D_rA), 64'hF);
    chk({nm, ".rB"}, 64'(D_rB), 64'hF);
    chk({nm, ".valC"}, D_valC, 64'h0);
    chk({nm, ".valP"}, D_valP, 64'h0);
  endtask

  task automatic chk_perf(input string nm);
    chk({nm, ".fetched"}, 64'(perf_fetched), 64'(ef));
    chk({nm, ".bubbles"}, 64'(perf_bubbles), 64'(eb));
    chk({nm, ".stalls"}, 64'(perf_stalls), 64'(es));
  endtask

  initial begin
    v[0]  = '{80'h0AF330, 0, 4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'd10, 0, 3'd1};
    v[1]  = '{80'h1260, 0, 4'h6, 4'h0, 4'h1, 4'h2, 64'd0, 64'd2, 0, 3'd1};
    v[2]  = '{80'h4563, 0, 4'h6, 4'h3, 4'h4, 4'h5, 64'd0, 64'd2, 0, 3'd1};
    v[3]  = '{80'h4564, 0, 4'h6, 4'h4, 4'h4, 4'h5, 64'd0, 64'd2, 0, 3'd4};
    v[4]  = '{80'h10, 0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 0, 3'd1};
    v[5]  = '{80'h00, 0, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 0, 3'd2};
    v[6]  = '{80'hC0, 0, 4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 0, 3'd4};
    v[7]  = '{80'h62, 1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 0, 3'd3};
    v[8]  = '{80'h4080, 0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h40, 64'd9, 1, 3'd1};
    v[9]  = '{80'h90, 0, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 0, 3'd1};
    v[10] = '{80'h3FA0, 0, 4'hA, 4'h0, 4'h3, 4'hF, 64'd0, 64'd2, 0, 3'd1};
    v[11] = '{80'h181250, 0, 4'h5, 4'h0, 4'h1, 4'h2, 64'h18, 64'd10, 0, 3'd1};
    v[12] = '{80'h3426, 0, 4'h2, 4'h6, 4'h3, 4'h4, 64'd0, 64'd2, 0, 3'd1};
    v[13] = '{80'h3427, 0, 4'h2, 4'h7, 4'h3, 4'h4, 64'd0, 64'd2, 0, 3'd4};
    v[14] = '{80'h8074, 0, 4'h7, 4'h4, 4'hF, 4'hF, 64'h80, 64'd9, 1, 3'd1};
    v[15] = '{80'h12344540, 0, 4'h4, 4'h0, 4'h4, 4'h5, 64'h1234, 64'd10, 0, 3'd1};
    v[16] = '{80'h01, 0, 4'h0, 4'h1, 4'hF, 4'hF, 64'd0, 64'd1, 0, 3'd4};
    v[17] = '{80'h0FB0, 0, 4'hB, 4'h0, 4'h0, 4'hF, 64'd0, 64'd2, 0, 3'd1};
    v[18] = '{80'h8877665544332211F330, 0, 4'h3, 4'h0, 4'hF, 4'h3,
              64'h8877665544332211, 64'd10, 0, 3'd1};
    v[19] = '{80'h10, 0, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 0, 3'd1};

    rst_n = 1'b0;
    F_stall = 0; D_stall = 0; D_bubble = 0;
    M_icode = 4'h1; M_Cnd = 0; M_valA = '0;
    W_icode = 4'h1; W_valM = '0;
    imem_data = 80'h10; imem_error = 0;
    tick();
    tick();
    chk("rst.addr", imem_addr, RPC);
    chk_bubble("rst");
    chk_perf("rst");

    rst_n = 1'b1;
    exp_pc = RPC;
    foreach (v[i]) begin
      imem_data = v[i].data;
      imem_error = v[i].err;
      #1;
      chk($sformatf("v%0d.addr", i), imem_addr, exp_pc);
      tick();
      chk($sformatf("v%0d.stat", i), 64'(D_stat), 64'(v[i].stat));
      chk($sformatf("v%0d.icode", i), 64'(D_icode), 64'(v[i].icode));
      chk($sformatf("v%0d.ifun", i), 64'(D_ifun), 64'(v[i].ifun));
      chk($sformatf("v%0d.rA", i), 64'(D_rA), 64'(v[i].ra));
      chk($sformatf("v%0d.rB", i), 64'(D_rB), 64'(v[i].rb));
      chk($sformatf("v%0d.valC", i), D_valC, v[i].valc);
      chk($sformatf("v%0d.valP", i), D_valP, exp_pc + v[i].len);
      exp_pc = v[i].jmp ? v[i].valc : exp_pc + v[i].len;
    end
    imem_error = 0;
    chk("tbl.addr", imem_addr, exp_pc);

    // jmp predicted taken, then resolved not taken in M
    imem_data = 80'h8070;
    jpc = exp_pc;
    tick();
    chk("jmp.pred", imem_addr, 64'h80);
    M_icode = 4'h7; M_Cnd = 1; W_icode = 4'h9; W_valM = 64'h555;
    #1;
    chk("ret.taken", imem_addr, 64'h555);
    M_Cnd = 0; M_valA = jpc + 64'd9;
    #1;
    chk("mispred.win", imem_addr, jpc + 64'd9);
    imem_data = 80'h10;
    tick();
    chk("mispred.valP", D_valP, jpc + 64'd10);
    M_icode = 4'h1; W_valM = 64'h300;
    #1;
    chk("ret.addr", imem_addr, 64'h300);
    tick();
    chk("ret.valP", D_valP, 64'h301);
    W_icode = 4'h1;
    #1;
    chk("ret.pred", imem_addr, 64'h301);

    // PC wrap through valP
    M_icode = 4'h7; M_Cnd = 0; M_valA = 64'hFFFF_FFFF_FFFF_FFFE;
    imem_data = 80'h0AF330;
    #1;
    chk("wrap.addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    M_icode = 4'h1;
    #1;
    chk("wrap.valP", D_valP, 64'd8);
    chk("wrap.pred", imem_addr, 64'd8);

    // stall 3 cycles
    F_stall = 1; D_stall = 1;
    imem_data = 80'h1260;
    repeat (3) tick();
    chk("stall.addr", imem_addr, 64'd8);
    chk("stall.icode", 64'(D_icode), 64'h3);
    chk("stall.rB", 64'(D_rB), 64'h3);
    chk("stall.valP", D_valP, 64'd8);
    F_stall = 0; D_stall = 0; D_bubble = 1;
    imem_data = 80'h0AF330;
    tick();
    D_bubble = 0;
    chk_bubble("bub");
    chk("bub.addr", imem_addr, 64'd18);

    imem_data = 80'h10;
    repeat (4) tick();
    chk("nop.addr", imem_addr, 64'd22);
    chk_perf("run");

    // async reset in mid-cycle
    #2;
    rst_n = 1'b0;
    ef = 0; eb = 0; es = 0;
    #1;
    chk("arst.addr", imem_addr, RPC);
    chk_bubble("arst");
    chk_perf("arst");
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("post.icode", 64'(D_icode), 64'h1);
    chk("post.valP", D_valP, RPC + 64'd1);
    chk("post.addr", imem_addr, RPC + 64'd1);
    chk_perf("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
